// File: rtl/shift_pkg.sv
// Shared opcode and state encodings for the multicycle shifter.
// The control-unit decoder imports this package too.
package shift_pkg;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Codes with bit 2 set are treated as PASS.
    function automatic logic op_is_shift(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shifter: applies a single SLL/SRL/SRA/ROR step.
// Any other opcode passes the operand through unchanged.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROR:  q = {d[0], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multicycle shifter: captures operand/amount on start, shifts one bit per clock,
// and pulses done for one cycle when the result is final.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   src,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   step_q;
    logic               accept;

    assign accept = (state_q == S_IDLE) && start;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_q)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= '0;
            op_q    <= OP_PASS;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((shamt != '0) && op_is_shift(op)) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                // count_q==1 means this edge performs the last step.
                if (count_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; operands are only captured on an accepted start.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        op_d    = op_q;
        if (accept) begin
            data_d  = src;
            count_d = shamt;
            op_d    = op;
        end else if (state_q == S_SHIFT) begin
            data_d  = step_q;
            count_d = count_q - SHAMT_W'(1);
        end
    end

    // Outputs.
    always_comb begin
        result = data_q;
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
    end

endmodule
